// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: RAW detection, load-use stall sequencing,
// memory-wait freeze, operand forwarding selects and a stall statistics counter.
module hazard_ctrl_unit #(
  parameter int          REG_ADDR_W = 4,
  parameter int unsigned FWD_EN     = 1,
  parameter int          STAT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Exe_WB_EN,
  input  logic                  Mem_WB_EN,
  input  logic                  EXE_MEM_R_EN,
  input  logic                  Two_src,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic [REG_ADDR_W-1:0] Exe_Dest,
  input  logic [REG_ADDR_W-1:0] Mem_Dest,
  input  logic                  mem_ready,
  input  logic                  clr_stats,
  output logic                  hazard_Detected,
  output logic                  freeze,
  output logic [1:0]            fwd_sel1,
  output logic [1:0]            fwd_sel2,
  output logic [1:0]            state,
  output logic [STAT_W-1:0]     stall_count
);

  // state    | meaning
  // IDLE     | normal issue, hazards evaluated
  // LU_STALL | one bubble inserted for a RAW / load-use hazard
  // MEM_WAIT | data memory busy, whole pipeline frozen
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        sel1_q, sel1_d, sel2_q, sel2_d;
  logic [STAT_W-1:0] cnt_q, cnt_d;

  logic m1e, m1m, m2e, m2m, raw_hazard, haz;

  function automatic logic [1:0] pick_src(input logic exe_hit, input logic mem_hit);
    if (exe_hit)      pick_src = 2'b01;
    else if (mem_hit) pick_src = 2'b10;
    else              pick_src = 2'b00;
  endfunction

  always_comb begin
    m1e = (src1 == Exe_Dest) & Exe_WB_EN;
    m1m = (src1 == Mem_Dest) & Mem_WB_EN;
    m2e = (src2 == Exe_Dest) & Exe_WB_EN & Two_src;
    m2m = (src2 == Mem_Dest) & Mem_WB_EN & Two_src;
    if (FWD_EN != 0) raw_hazard = (m1e | m2e) & EXE_MEM_R_EN;
    else             raw_hazard = m1e | m1m | m2e | m2m;
  end

  always_comb begin
    haz     = 1'b0;
    state_d = state_q;
    unique case (state_q)
      IDLE:     haz = raw_hazard;
      LU_STALL: haz = (FWD_EN != 0) ? 1'b0 : raw_hazard;
      default:  haz = 1'b0;
    endcase
    // A pending memory access dominates every other request.
    freeze          = ~mem_ready;
    hazard_Detected = haz & mem_ready;

    if (!mem_ready) begin
      state_d = MEM_WAIT;
    end else begin
      unique case (state_q)
        IDLE:     state_d = hazard_Detected ? LU_STALL : IDLE;
        LU_STALL: state_d = hazard_Detected ? LU_STALL : IDLE;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sel1_d = sel1_q;
    sel2_d = sel2_q;
    if (FWD_EN == 0) begin
      sel1_d = 2'b00;
      sel2_d = 2'b00;
    end else if (!freeze) begin
      if (hazard_Detected) begin
        sel1_d = 2'b00;
        sel2_d = 2'b00;
      end else begin
        sel1_d = pick_src(m1e, m1m);
        sel2_d = pick_src(m2e, m2m);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr_stats)
      cnt_d = '0;
    else if ((hazard_Detected | freeze) && (cnt_q != {STAT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel1_q  <= 2'b00;
      sel2_q  <= 2'b00;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel1_q  <= sel1_d;
      sel2_q  <= sel2_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fwd_sel1    = sel1_q;
  assign fwd_sel2    = sel2_q;
  assign state       = state_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: forwarding, stall-only and narrow-counter
// instances share one stimulus set; each scenario checks the relevant instance.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst, exe_wb_en, mem_wb_en, exe_mem_r_en, two_src, mem_ready, clr_stats;
  logic [3:0] src1, src2, exe_dest, mem_dest;

  logic        hd_f, fz_f, hd_n, fz_n, hd_s, fz_s;
  logic [1:0]  s1_f, s2_f, st_f, s1_n, s2_n, st_n, s1_s, s2_s, st_s;
  logic [15:0] sc_f, sc_n;
  logic [2:0]  sc_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_ADDR_W(4), .FWD_EN(1), .STAT_W(16)) u_fwd (
    .clk(clk), .rst(rst), .Exe_WB_EN(exe_wb_en), .Mem_WB_EN(mem_wb_en),
    .EXE_MEM_R_EN(exe_mem_r_en), .Two_src(two_src), .src1(src1), .src2(src2),
    .Exe_Dest(exe_dest), .Mem_Dest(mem_dest), .mem_ready(mem_ready), .clr_stats(clr_stats),
    .hazard_Detected(hd_f), .freeze(fz_f), .fwd_sel1(s1_f), .fwd_sel2(s2_f),
    .state(st_f), .stall_count(sc_f));

  hazard_ctrl_unit #(.REG_ADDR_W(4), .FWD_EN(0), .STAT_W(16)) u_nofwd (
    .clk(clk), .rst(rst), .Exe_WB_EN(exe_wb_en), .Mem_WB_EN(mem_wb_en),
    .EXE_MEM_R_EN(exe_mem_r_en), .Two_src(two_src), .src1(src1), .src2(src2),
    .Exe_Dest(exe_dest), .Mem_Dest(mem_dest), .mem_ready(mem_ready), .clr_stats(clr_stats),
    .hazard_Detected(hd_n), .freeze(fz_n), .fwd_sel1(s1_n), .fwd_sel2(s2_n),
    .state(st_n), .stall_count(sc_n));

  hazard_ctrl_unit #(.REG_ADDR_W(4), .FWD_EN(1), .STAT_W(3)) u_sat (
    .clk(clk), .rst(rst), .Exe_WB_EN(exe_wb_en), .Mem_WB_EN(mem_wb_en),
    .EXE_MEM_R_EN(exe_mem_r_en), .Two_src(two_src), .src1(src1), .src2(src2),
    .Exe_Dest(exe_dest), .Mem_Dest(mem_dest), .mem_ready(mem_ready), .clr_stats(clr_stats),
    .hazard_Detected(hd_s), .freeze(fz_s), .fwd_sel1(s1_s), .fwd_sel2(s2_s),
    .state(st_s), .stall_count(sc_s));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic quiet();
    exe_wb_en = 0; mem_wb_en = 0; exe_mem_r_en = 0; two_src = 0;
    src1 = 4'd1; src2 = 4'd2; exe_dest = 4'd8; mem_dest = 4'd9;
    mem_ready = 1; clr_stats = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    quiet();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic load_use_src1();
    src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1; exe_mem_r_en = 1;
  endtask

  initial begin
    quiet();
    rst = 1;
    tick();
    mem_ready = 0;
    #1;
    check("freeze_in_reset", fz_f, 1);
    check("hazard_in_reset", hd_f, 0);
    tick();
    check("reset_state", st_f, 0);
    check("reset_sel1", s1_f, 0);
    check("reset_sel2", s2_f, 0);
    check("reset_count", sc_f, 0);
    mem_ready = 1;
    tick();
    rst = 0;

    // Load-use hazard with forwarding: one bubble, then EXE forward.
    do_reset();
    load_use_src1();
    #1;
    check("lu_hazard", hd_f, 1);
    check("lu_state_idle", st_f, 0);
    tick();
    check("lu_state_stall", st_f, 1);
    check("lu_sel1_bubble", s1_f, 0);
    mem_dest = 4'd3; mem_wb_en = 1;
    #1;
    check("lu_no_second_bubble", hd_f, 0);
    tick();
    check("lu_back_idle", st_f, 0);
    check("lu_sel1_fwd", s1_f, 1);
    check("lu_count", sc_f, 1);
    quiet();

    // Matching destination without write-back never stalls or forwards.
    src1 = 4'd3; exe_dest = 4'd3; exe_mem_r_en = 1; mem_dest = 4'd3;
    #1;
    check("nowb_fwd_hazard", hd_f, 0);
    check("nowb_nofwd_hazard", hd_n, 0);
    tick();
    check("nowb_sel1", s1_f, 0);

    // MEM-stage forward on src2, gated by Two_src.
    do_reset();
    src1 = 4'd1; exe_dest = 4'd9; exe_wb_en = 1;
    src2 = 4'd5; mem_dest = 4'd5; mem_wb_en = 1; two_src = 1;
    #1;
    check("mem_fwd_no_stall", hd_f, 0);
    tick();
    check("mem_fwd_sel2", s2_f, 2);
    check("mem_fwd_sel1", s1_f, 0);
    check("nofwd_sel2_const", s2_n, 0);
    two_src = 0;
    tick();
    check("two_src_off_sel2", s2_f, 0);

    // Stall-only mode: EXE then MEM match gives two stall cycles.
    do_reset();
    src1 = 4'd2; exe_dest = 4'd2; exe_wb_en = 1;
    #1;
    check("nofwd_haz_exe", hd_n, 1);
    tick();
    check("nofwd_state_stall", st_n, 1);
    exe_wb_en = 0; mem_dest = 4'd2; mem_wb_en = 1;
    #1;
    check("nofwd_haz_mem", hd_n, 1);
    tick();
    check("nofwd_state_hold", st_n, 1);
    quiet();
    #1;
    check("nofwd_haz_clear", hd_n, 0);
    tick();
    check("nofwd_state_idle", st_n, 0);
    check("nofwd_count", sc_n, 2);
    check("nofwd_sel1", s1_n, 0);

    // Memory wait over a load-use hazard: freeze wins, selects held.
    do_reset();
    src2 = 4'd5; mem_dest = 4'd5; mem_wb_en = 1; two_src = 1;
    tick();
    check("mw_pre_sel2", s2_f, 2);
    load_use_src1();
    mem_ready = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("mw_freeze", fz_f, 1);
      check("mw_hazard_masked", hd_f, 0);
      tick();
      check("mw_state", st_f, 2);
      check("mw_sel2_held", s2_f, 2);
    end
    mem_ready = 1;
    #1;
    check("mw_exit_hazard", hd_f, 0);
    tick();
    check("mw_exit_idle", st_f, 0);
    #1;
    check("mw_reeval_hazard", hd_f, 1);
    tick();
    check("mw_reeval_state", st_f, 1);
    check("mw_count", sc_f, 5);
    quiet();

    // Narrow counter saturates, clear beats a simultaneous stall.
    do_reset();
    mem_ready = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("sat_count", sc_s, (i > 7) ? 7 : i);
    end
    clr_stats = 1;
    tick();
    check("sat_clr_wins", sc_s, 0);
    clr_stats = 0;
    mem_ready = 1;
    tick();
    check("sat_after_clr", sc_s, 0);

    // Reset in the middle of a stall.
    do_reset();
    load_use_src1();
    tick();
    check("rst_pre_stall", st_f, 1);
    check("rst_pre_count", sc_f, 1);
    rst = 1;
    tick();
    check("rst_state", st_f, 0);
    check("rst_count", sc_f, 0);
    check("rst_sel1", s1_f, 0);
    rst = 0;
    quiet();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
